// File: rtl/vx_operand_gather_if.sv
// Operands channel from operand gather to dispatch: valid/ready with the full operand bundle.
// The master holds every field stable while valid is high and ready is low.
interface vx_operand_gather_if #(
  parameter int THREAD_CNT = 4,
  parameter int XLEN       = 32,
  parameter int WIS_W      = 2,
  parameter int META_W     = 128
);
  logic                       valid;
  logic                       ready;
  logic [WIS_W-1:0]           wis;
  logic [META_W-1:0]          meta;
  logic [THREAD_CNT*XLEN-1:0] rs1_data;
  logic [THREAD_CNT*XLEN-1:0] rs2_data;
  logic [THREAD_CNT*XLEN-1:0] rs3_data;

  modport master (output valid, wis, meta, rs1_data, rs2_data, rs3_data, input ready);
  modport slave  (input valid, wis, meta, rs1_data, rs2_data, rs3_data, output ready);
endinterface

// File: rtl/vx_operand_gather.sv
// Gathers rs1/rs2/rs3 of one issued instruction from a single-port GPR bank and presents the bundle.
// Latency k+2 cycles for k reads (1 if none); stalls on gpr_req_ready=0 and holds the bundle until out.ready.
module vx_operand_gather #(
  parameter int THREAD_CNT = 4,
  parameter int XLEN       = 32,
  parameter int NR_BITS    = 5,
  parameter int WIS_W      = 2,
  parameter int META_W     = 128
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIS_W-1:0]           in_wis,
  input  logic [META_W-1:0]          in_meta,
  input  logic [NR_BITS-1:0]         in_rs1,
  input  logic [NR_BITS-1:0]         in_rs2,
  input  logic [NR_BITS-1:0]         in_rs3,
  input  logic [2:0]                 in_use_rs,
  output logic                       gpr_req_valid,
  input  logic                       gpr_req_ready,
  output logic [WIS_W-1:0]           gpr_req_wis,
  output logic [NR_BITS-1:0]         gpr_req_reg,
  input  logic [THREAD_CNT*XLEN-1:0] gpr_rsp_data,
  vx_operand_gather_if.master        out
);
  localparam int DW = THREAD_CNT * XLEN;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  state_t                    state_q, state_d;
  logic [WIS_W-1:0]          wis_q;
  logic [META_W-1:0]         meta_q;
  logic [2:0][NR_BITS-1:0]   idx_q;
  logic [2:0][DW-1:0]        data_q;
  logic [2:0]                pend_q;
  logic [2:0]                pend_in;
  logic [2:0]                pend_nxt;
  logic [1:0]                sel;
  logic [1:0]                tag_q;
  logic                      tag_vld_q;
  logic                      accept;
  logic                      grant;

  // x0 always reads as zero, so it never costs a bank read
  assign pend_in = in_use_rs & {in_rs3 != '0, in_rs2 != '0, in_rs1 != '0};

  always_comb begin
    sel = 2'd2;
    if (pend_q[0])      sel = 2'd0;
    else if (pend_q[1]) sel = 2'd1;
  end

  assign pend_nxt      = pend_q & ~(3'b001 << sel);
  assign in_ready      = (state_q == IDLE);
  assign accept        = in_valid && in_ready;
  assign gpr_req_valid = (state_q == READ);
  assign grant         = gpr_req_valid && gpr_req_ready;
  assign gpr_req_wis   = wis_q;
  assign gpr_req_reg   = idx_q[sel];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (pend_in != 3'b000) ? READ : OUT;
      READ:    if (grant && pend_nxt == 3'b000) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (out.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wis_q     <= '0;
      meta_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      pend_q    <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        wis_q  <= in_wis;
        meta_q <= in_meta;
        idx_q  <= {in_rs3, in_rs2, in_rs1};
        pend_q <= pend_in;
        data_q <= '0;
      end
      if (grant) begin
        pend_q <= pend_nxt;
        tag_q  <= sel;
      end
      // the bank answers exactly one cycle after each grant
      tag_vld_q <= grant;
      if (tag_vld_q) data_q[tag_q] <= gpr_rsp_data;
    end
  end

  assign out.valid    = (state_q == OUT);
  assign out.wis      = wis_q;
  assign out.meta     = meta_q;
  assign out.rs1_data = data_q[0];
  assign out.rs2_data = data_q[1];
  assign out.rs3_data = data_q[2];
endmodule

// File: tb/tb_vx_operand_gather.sv
// Directed table-driven bench for vx_operand_gather with a one-cycle-latency GPR bank model.
module tb_vx_operand_gather;
  localparam int TC = 4, XL = 32, NB = 5, WW = 2, MW = 128;
  localparam int DW = TC * XL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_wis;
  logic [MW-1:0] in_meta;
  logic [NB-1:0] in_rs1, in_rs2, in_rs3;
  logic [2:0]    in_use_rs;
  logic          gpr_req_valid;
  logic          gpr_req_ready;
  logic [WW-1:0] gpr_req_wis;
  logic [NB-1:0] gpr_req_reg;
  logic [DW-1:0] gpr_rsp_data;

  vx_operand_gather_if #(.THREAD_CNT(TC), .XLEN(XL), .WIS_W(WW), .META_W(MW)) opnd ();

  vx_operand_gather #(.THREAD_CNT(TC), .XLEN(XL), .NR_BITS(NB), .WIS_W(WW), .META_W(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_meta(in_meta),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_use_rs(in_use_rs),
    .gpr_req_valid(gpr_req_valid), .gpr_req_ready(gpr_req_ready),
    .gpr_req_wis(gpr_req_wis), .gpr_req_reg(gpr_req_reg), .gpr_rsp_data(gpr_rsp_data),
    .out(opnd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    use_rs;
    logic [NB-1:0] rs1, rs2, rs3;
    logic [WW-1:0] wis;
    logic [MW-1:0] meta;
    int            gstall_at;   // request number to stall, -1 for none
    int            gstall_n;
    int            ostall_n;
    int            exp_lat;
    int            exp_nreq;
    logic [NB-1:0] exp_reg [3];
    logic [XL-1:0] exp_d1, exp_d2, exp_d3;
  } vec_t;

  vec_t          vecs [7];
  logic [XL-1:0] bank [32];
  int            n_cmp = 0;
  int            n_err = 0;
  localparam logic [DW-1:0] GARBAGE = {TC{32'hDEAD_BEEF}};

  function automatic logic [DW-1:0] rep(input logic [XL-1:0] v);
    return {TC{v}};
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int            cyc, nreq, gst, ost, lat;
    logic          prev_grant, done, held, busy_rdy, unstable, req_moved;
    logic [NB-1:0] prev_reg, held_reg;
    logic [NB-1:0] regs [3];
    logic [MW-1:0] snap_meta;
    logic [DW-1:0] snap_d1;
    wait_idle();
    in_valid = 1'b1; in_use_rs = v.use_rs; in_wis = v.wis; in_meta = v.meta;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rs3 = v.rs3;
    @(posedge clk); #1;
    in_valid = 1'b0; in_rs1 = 5'd31; in_rs2 = 5'd30; in_rs3 = 5'd29;
    in_meta = ~v.meta; in_wis = ~v.wis; in_use_rs = 3'b111;
    cyc = 1; nreq = 0; gst = v.gstall_n; ost = v.ostall_n; lat = -1;
    prev_grant = 0; prev_reg = '0; done = 0; held = 0; held_reg = '0;
    busy_rdy = 0; unstable = 0; req_moved = 0;
    regs[0] = '0; regs[1] = '0; regs[2] = '0;
    snap_meta = '0; snap_d1 = '0;
    while (cyc < 40 && !done) begin
      gpr_rsp_data = prev_grant ? rep(bank[prev_reg]) : GARBAGE;
      prev_grant = 0;
      if (in_ready) busy_rdy = 1;
      gpr_req_ready = 1'b1;
      if (gpr_req_valid) begin
        if (held && gpr_req_reg !== held_reg) req_moved = 1;
        if (nreq == v.gstall_at && gst > 0) begin
          gpr_req_ready = 1'b0;
          gst--;
          held = 1; held_reg = gpr_req_reg;
        end else begin
          held = 0;
          if (nreq < 3) regs[nreq] = gpr_req_reg;
          chk($sformatf("v%0d_req_wis", id), MW'(gpr_req_wis), MW'(v.wis));
          nreq++;
          prev_grant = 1; prev_reg = gpr_req_reg;
        end
      end
      if (opnd.valid) begin
        if (lat < 0) begin
          lat = cyc; snap_meta = opnd.meta; snap_d1 = opnd.rs1_data;
        end else if (opnd.meta !== snap_meta || opnd.rs1_data !== snap_d1) unstable = 1;
        if (ost > 0) begin
          opnd.ready = 1'b0; ost--;
        end else begin
          opnd.ready = 1'b1; done = 1;
          chk($sformatf("v%0d_wis", id), MW'(opnd.wis), MW'(v.wis));
          chk($sformatf("v%0d_meta", id), opnd.meta, v.meta);
          chk($sformatf("v%0d_rs1", id), MW'(opnd.rs1_data), MW'(rep(v.exp_d1)));
          chk($sformatf("v%0d_rs2", id), MW'(opnd.rs2_data), MW'(rep(v.exp_d2)));
          chk($sformatf("v%0d_rs3", id), MW'(opnd.rs3_data), MW'(rep(v.exp_d3)));
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    opnd.ready = 1'b0;
    gpr_rsp_data = GARBAGE;
    if (!done) chk($sformatf("v%0d_timeout", id), 0, 1);
    chk($sformatf("v%0d_latency", id), MW'(lat), MW'(v.exp_lat));
    chk($sformatf("v%0d_nreq", id), MW'(nreq), MW'(v.exp_nreq));
    for (int i = 0; i < v.exp_nreq; i++)
      chk($sformatf("v%0d_reg%0d", id, i), MW'(regs[i]), MW'(v.exp_reg[i]));
    chk($sformatf("v%0d_busy_in_ready", id), MW'(busy_rdy), 0);
    chk($sformatf("v%0d_out_stable", id), MW'(unstable), 0);
    if (v.gstall_n > 0) chk($sformatf("v%0d_req_hold", id), MW'(req_moved), 0);
    chk($sformatf("v%0d_post_in_ready", id), MW'(in_ready), 1);
    chk($sformatf("v%0d_post_out_valid", id), MW'(opnd.valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h100 + i;
    bank[5] = 32'hA; bank[7] = 32'hB; bank[9] = 32'hC; bank[3] = 32'h33; bank[12] = 32'hC0;

    //        use     rs1    rs2    rs3    wis    meta           gst  gn ost lat nreq  regs              d1       d2       d3
    vecs[0] = '{3'b111, 5'd5, 5'd7, 5'd9, 2'd1, {4{32'h1111_0001}}, -1, 0, 0, 5, 3, '{5'd5, 5'd7, 5'd9}, 32'hA, 32'hB, 32'hC};
    vecs[1] = '{3'b011, 5'd0, 5'd3, 5'd9, 2'd2, {4{32'h2222_0002}}, -1, 0, 0, 3, 1, '{5'd3, 5'd0, 5'd0}, 32'h0, 32'h33, 32'h0};
    vecs[2] = '{3'b000, 5'd5, 5'd7, 5'd9, 2'd3, {4{32'h3333_0003}}, -1, 0, 0, 1, 0, '{5'd0, 5'd0, 5'd0}, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{3'b111, 5'd5, 5'd7, 5'd9, 2'd2, {4{32'h4444_0004}},  1, 2, 0, 7, 3, '{5'd5, 5'd7, 5'd9}, 32'hA, 32'hB, 32'hC};
    vecs[4] = '{3'b111, 5'd7, 5'd5, 5'd3, 2'd1, {4{32'h5555_0005}}, -1, 0, 4, 5, 3, '{5'd7, 5'd5, 5'd3}, 32'hB, 32'hA, 32'h33};
    vecs[5] = '{3'b100, 5'd5, 5'd7, 5'd12, 2'd0, {4{32'h6666_0006}}, -1, 0, 0, 3, 1, '{5'd12, 5'd0, 5'd0}, 32'h0, 32'h0, 32'hC0};
    vecs[6] = '{3'b111, 5'd0, 5'd0, 5'd0, 2'd3, {4{32'h7777_0007}}, -1, 0, 0, 1, 0, '{5'd0, 5'd0, 5'd0}, 32'h0, 32'h0, 32'h0};

    reset_n = 1'b0; in_valid = 1'b0; in_wis = '0; in_meta = '0;
    in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_use_rs = '0;
    gpr_req_ready = 1'b1; gpr_rsp_data = GARBAGE; opnd.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", MW'(opnd.valid), 0);
    chk("rst_req_valid", MW'(gpr_req_valid), 0);
    chk("rst_in_ready", MW'(in_ready), 1);
    chk("rst_out_meta", opnd.meta, '0);
    chk("rst_out_wis", MW'(opnd.wis), 0);
    chk("rst_out_rs3", MW'(opnd.rs3_data), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // reset while READ: the grant of cycle 1 answers in cycle 2, right as reset hits
    wait_idle();
    in_valid = 1'b1; in_use_rs = 3'b111; in_rs1 = 5'd5; in_rs2 = 5'd7; in_rs3 = 5'd9;
    in_wis = 2'd1; in_meta = {4{32'h9999_0009}};
    @(posedge clk); #1;
    in_valid = 1'b0; gpr_req_ready = 1'b1;
    chk("mid_req_valid_before", MW'(gpr_req_valid), 1);
    @(posedge clk); #1;
    gpr_rsp_data = rep(32'hA);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", MW'(opnd.valid), 0);
    chk("mid_rst_req_valid", MW'(gpr_req_valid), 0);
    chk("mid_rst_in_ready", MW'(in_ready), 1);
    chk("mid_rst_meta", opnd.meta, '0);
    @(negedge clk); reset_n = 1'b1;
    gpr_rsp_data = rep(32'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_rs1", MW'(opnd.rs1_data), 0);
    chk("post_rst_rs2", MW'(opnd.rs2_data), 0);
    chk("post_rst_meta", opnd.meta, '0);
    chk("post_rst_out_valid", MW'(opnd.valid), 0);
    chk("post_rst_req_valid", MW'(gpr_req_valid), 0);
    gpr_rsp_data = GARBAGE;

    run_vec(7, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
